// File: rtl/coin_acceptor_if.sv
// Coin-sensor bundle between the sensor front end and the vending logic.
//   coin50_raw / coin100_raw : asynchronous sensor lines (high while a coin passes)
//   in50 / in100             : one-cycle accepted-coin strobes
//   jam50 / jam100           : jam level per slot (jammed or waiting for quiet)
//   cnt50 / cnt100           : saturating accepted-coin counts
// master = sensor/consumer side, slave = coin_acceptor side.
interface coin_acceptor_if;
   logic       coin50_raw;
   logic       coin100_raw;
   logic       in50;
   logic       in100;
   logic       jam50;
   logic       jam100;
   logic [7:0] cnt50;
   logic [7:0] cnt100;

   modport master (
      output coin50_raw, coin100_raw,
      input  in50, in100, jam50, jam100, cnt50, cnt100
   );

   modport slave (
      input  coin50_raw, coin100_raw,
      output in50, in100, jam50, jam100, cnt50, cnt100
   );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: per slot, a 2-flop synchroniser, a width-qualifying
// FSM (glitch / accept / jam / quiet), a registered one-cycle strobe and a
// saturating 8-bit accepted-coin counter. The two slots are independent.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : coin_acceptor_if.slave (raw sensors in; strobes, jams, counts out)
module coin_acceptor #(
   parameter int unsigned MIN_HIGH = 4,
   parameter int unsigned MAX_HIGH = 200,
   parameter int unsigned QUIET    = 16
) (
   input logic            clock,
   input logic            reset,
   coin_acceptor_if.slave bus
);

   localparam logic [7:0] MIN_W   = 8'(MIN_HIGH);
   localparam logic [7:0] MAX_W   = 8'(MAX_HIGH);
   localparam logic [7:0] QUIET_W = 8'(QUIET);

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_JAM, S_QUIET} state_t;

   logic [1:0] raw;
   logic [1:0] strobe_v;
   logic [1:0] jam_v;
   logic [7:0] cnt_v [2];

   assign raw = {bus.coin100_raw, bus.coin50_raw};

   for (genvar c = 0; c < 2; c++) begin : g_ch
      logic       sync1, sync2;
      state_t     state, state_n;
      logic [7:0] w, w_n;
      logic [7:0] q, q_n;
      logic       accept;
      logic       strobe;
      logic [7:0] cnt;

      always_ff @(posedge clock) begin
         if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            state  <= S_IDLE;
            w      <= '0;
            q      <= '0;
            strobe <= 1'b0;
            cnt    <= '0;
         end else begin
            sync1  <= raw[c];
            sync2  <= sync1;
            state  <= state_n;
            w      <= w_n;
            q      <= q_n;
            strobe <= accept;
            if (accept && (cnt != '1))
               cnt <= cnt + 8'd1;
         end
      end

      always_comb begin
         state_n = state;
         w_n     = w;
         q_n     = q;
         accept  = 1'b0;
         case (state)
            S_IDLE: begin
               if (sync2) begin
                  state_n = S_HIGH;
                  w_n     = 8'd1;
               end
            end
            S_HIGH: begin
               if (sync2) begin
                  if (w == MAX_W)
                     state_n = S_JAM;
                  else
                     w_n = w + 8'd1;
               end else begin
                  accept  = (w >= MIN_W);
                  state_n = S_IDLE;
               end
            end
            // q counts low cycles seen so far, including the current one, so
            // the jam drops on exactly the QUIET-th consecutive low cycle.
            S_JAM: begin
               if (!sync2) begin
                  if (QUIET_W == 8'd1) begin
                     state_n = S_IDLE;
                  end else begin
                     state_n = S_QUIET;
                     q_n     = 8'd1;
                  end
               end
            end
            S_QUIET: begin
               if (sync2) begin
                  state_n = S_JAM;
               end else begin
                  q_n = q + 8'd1;
                  if (q_n == QUIET_W)
                     state_n = S_IDLE;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end

      assign strobe_v[c] = strobe;
      assign jam_v[c]    = (state == S_JAM) || (state == S_QUIET);
      assign cnt_v[c]    = cnt;
   end

   assign bus.in50   = strobe_v[0];
   assign bus.in100  = strobe_v[1];
   assign bus.jam50  = jam_v[0];
   assign bus.jam100 = jam_v[1];
   assign bus.cnt50  = cnt_v[0];
   assign bus.cnt100 = cnt_v[1];

endmodule
